// File: rtl/vga_state_snapshot_pkg.sv
// Purpose : shared types and constants for the VGA state snapshot block.
// Latency : n/a (types, constants and a width helper only).
// Backpr. : n/a.
package snapshot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } snap_state_e;

    localparam int NREG_DEF       = 8;
    localparam int NRAM_DEF       = 8;
    localparam int HIST_DEPTH_DEF = 8;
    localparam int W_DEF          = 32;

    // One slot per register, per RAM word, plus the PC.
    localparam int SNAP_WORDS = NREG_DEF + NRAM_DEF + 1;

    // The copy index must reach NREG+NRAM (the PC slot).
    function automatic int snap_idx_w(input int nreg, input int nram);
        return $clog2(nreg + nram + 1);
    endfunction

    localparam int SNAP_IDX_W = snap_idx_w(NREG_DEF, NRAM_DEF);

endpackage

// File: rtl/vga_state_snapshot_if.sv
// Purpose : bundle between CPU/VGA side (master) and the snapshot block (slave).
// Latency : n/a (wiring only).
// Backpr. : none; all strobes are single-cycle pulses with no ready path.
// Ports   : live CPU state + vblank/retire strobes in, shadow state,
//           status counters and history read port out.
interface vga_state_snapshot_if #(
    parameter int NREG       = 8,
    parameter int NRAM       = 8,
    parameter int HIST_DEPTH = 8,
    parameter int W          = 32
);
    localparam int HW = $clog2(HIST_DEPTH);

    logic                     vblank_start;
    logic [NREG-1:0][W-1:0]   register_file;
    logic [NRAM-1:0][W-1:0]   ram;
    logic [14:0]              pc_for_vga;
    logic                     wb_valid_pulse;
    logic [W-1:0]             wb_instruction;
    logic [HW-1:0]            hist_rd_idx;

    logic [NREG-1:0][W-1:0]   snap_regs;
    logic [NRAM-1:0][W-1:0]   snap_ram;
    logic [14:0]              snap_pc;
    logic                     snap_busy;
    logic                     snap_done;
    logic [7:0]               frame_seq;
    logic [7:0]               missed_frames;
    logic [15:0]              retired_count;
    logic [W-1:0]             hist_rd_data;
    logic [HW:0]              hist_count;

    modport master (
        output vblank_start, register_file, ram, pc_for_vga,
               wb_valid_pulse, wb_instruction, hist_rd_idx,
        input  snap_regs, snap_ram, snap_pc, snap_busy, snap_done,
               frame_seq, missed_frames, retired_count, hist_rd_data, hist_count
    );

    modport slave (
        input  vblank_start, register_file, ram, pc_for_vga,
               wb_valid_pulse, wb_instruction, hist_rd_idx,
        output snap_regs, snap_ram, snap_pc, snap_busy, snap_done,
               frame_seq, missed_frames, retired_count, hist_rd_data, hist_count
    );
endinterface

// File: rtl/vga_state_snapshot_hist_ring.sv
// Purpose : ring of the last DEPTH retired instructions, newest-relative read.
// Latency : read data registered, 1 cycle after rd_idx; writes take effect next cycle.
// Backpr. : none; every wr_vld is accepted, oldest entry overwritten when full.
// Ports   : clk/rst, wr_vld/wr_dat write strobe, rd_idx (0 = newest) -> rd_dat,
//           count = valid entries saturating at DEPTH.
module hist_ring #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    logic [DEPTH-1:0][W-1:0] ring_q, ring_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [W-1:0]            rd_dat_q, rd_dat_d;
    logic [AW-1:0]           rd_slot;

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_vld) begin
            ring_d[wr_ptr_q] = wr_dat;
            // DEPTH is a power of two, so the pointer wraps for free.
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + (AW+1)'(1);
            end
        end
        // Read uses pre-write pointer and contents, so a same-cycle write
        // never shows up in the read of that cycle.
        rd_slot = wr_ptr_q - AW'(1) - rd_idx;
        if ({1'b0, rd_idx} >= count_q) begin
            rd_dat_d = '0;
        end else begin
            rd_dat_d = ring_q[rd_slot];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q   <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;
    assign count  = count_q;

endmodule

// File: rtl/vga_state_snapshot.sv
// Purpose : copy regs, RAM words and PC into shadows once per vblank, one word
//           per cycle; count frames/misses/retires; optional retire history
//           ring enabled by macro SNAPSHOT_HIST_EN.
// Latency : snap_done NREG+NRAM+2 cycles after vblank_start (18 by default).
// Backpr. : none; vblank_start while busy is dropped and counted in missed_frames.
// Ports   : CLOCK_50, reset (sync, active high), bus (slave modport).
module vga_state_snapshot
    import snapshot_pkg::*;
#(
    parameter int NREG       = NREG_DEF,
    parameter int NRAM       = NRAM_DEF,
    parameter int HIST_DEPTH = HIST_DEPTH_DEF,
    parameter int W          = W_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    vga_state_snapshot_if.slave bus
);
    localparam int IW = snap_idx_w(NREG, NRAM);
    localparam int RW = $clog2(NREG);
    localparam int MW = $clog2(NRAM);

    snap_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          ram_off;
    logic [NREG-1:0][W-1:0] regs_q, regs_d;
    logic [NRAM-1:0][W-1:0] ram_q, ram_d;
    logic [14:0]            pc_q, pc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [7:0]             frame_q, frame_d;
    logic [7:0]             missed_q, missed_d;
    logic [15:0]            retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        regs_d    = regs_q;
        ram_d     = ram_q;
        pc_d      = pc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        frame_d   = frame_q;
        missed_d  = missed_q;
        retired_d = retired_q;
        ram_off   = idx_q - IW'(NREG);

        case (state_q)
            IDLE: begin
                if (bus.vblank_start) begin
                    state_d = COPY;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            COPY: begin
                busy_d = 1'b1;
                idx_d  = idx_q + IW'(1);
                // Live value sampled in this very cycle, so late CPU writes to
                // not-yet-copied words are still picked up.
                if (idx_q < IW'(NREG)) begin
                    regs_d[idx_q[RW-1:0]] = bus.register_file[idx_q[RW-1:0]];
                end else if (idx_q < IW'(NREG + NRAM)) begin
                    ram_d[ram_off[MW-1:0]] = bus.ram[ram_off[MW-1:0]];
                end else begin
                    pc_d    = bus.pc_for_vga;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    frame_d = frame_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.vblank_start && state_q != IDLE && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end

        if (bus.wb_valid_pulse) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            regs_q    <= '0;
            ram_q     <= '0;
            pc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            frame_q   <= '0;
            missed_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            regs_q    <= regs_d;
            ram_q     <= ram_d;
            pc_q      <= pc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            frame_q   <= frame_d;
            missed_q  <= missed_d;
            retired_q <= retired_d;
        end
    end

    assign bus.snap_regs     = regs_q;
    assign bus.snap_ram      = ram_q;
    assign bus.snap_pc       = pc_q;
    assign bus.snap_busy     = busy_q;
    assign bus.snap_done     = done_q;
    assign bus.frame_seq     = frame_q;
    assign bus.missed_frames = missed_q;
    assign bus.retired_count = retired_q;

`ifdef SNAPSHOT_HIST_EN
    hist_ring #(
        .DEPTH (HIST_DEPTH),
        .W     (W)
    ) u_hist_ring (
        .clk    (CLOCK_50),
        .rst    (reset),
        .wr_vld (bus.wb_valid_pulse),
        .wr_dat (bus.wb_instruction),
        .rd_idx (bus.hist_rd_idx),
        .rd_dat (bus.hist_rd_data),
        .count  (bus.hist_count)
    );
`else
    // No history storage: read port and count are constant zero.
    logic unused_hist;
    assign unused_hist      = ^{bus.hist_rd_idx, bus.wb_instruction};
    assign bus.hist_rd_data = '0;
    assign bus.hist_count   = '0;
`endif

endmodule
